vga_timing_gen: RTL and testbench

- Generates 640x480@60 Hz VGA raster timing from the 25.175 MHz pixel clock.
- Produces pixel coordinates, an active-video flag and the sync pulses.
- Feeds x/y/active to the overlay generators (emblem, text, background) and hsync/vsync to the output pin register.
- All outputs are registered, so downstream combinational overlays see glitch-free coordinates.

---
 rtl/vga_timing_gen.sv | 125 ++++++++++++
 tb/tb_vga_timing_gen.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator: pixel/line counters with registered coordinate and sync decodes
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST       = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST       = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       active_q, active_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  logic h_last, v_last, in_hsync, in_vsync;

  always_comb begin
    h_last   = (h_cnt_q == H_LAST);
    v_last   = (v_cnt_q == V_LAST);
    in_hsync = (h_cnt_q >= H_SYNC_START) && (h_cnt_q < H_SYNC_END);
    in_vsync = (v_cnt_q >= V_SYNC_START) && (v_cnt_q < V_SYNC_END);

    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_cnt_d   = frame_cnt_q;
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_count_d = frame_count_q;

    if (ena) begin
      h_cnt_d = h_last ? 10'd0 : h_cnt_q + 10'd1;
      if (h_last) begin
        v_cnt_d = v_last ? 10'd0 : v_cnt_q + 10'd1;
        if (v_last) begin
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end

      // Output stage decodes the pre-increment counters, so everything lines up with x/y.
      x_d           = h_cnt_q;
      y_d           = v_cnt_q;
      active_d      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hsync_d       = in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d       = in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      line_start_d  = (h_cnt_q == 10'd0);
      frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
      frame_count_d = frame_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b0;
      hsync_q       <= ~SYNC_ACTIVE;
      vsync_q       <= ~SYNC_ACTIVE;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - checks a full-size 640x480 instance and a shrunken instance for frame-level behaviour
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       b_rst_n, b_ena, s_rst_n, s_ena;
  logic [9:0] b_x, b_y, s_x, s_y;
  logic       b_act, b_hs, b_vs, b_ls, b_fs;
  logic       s_act, s_hs, s_vs, s_ls, s_fs;
  logic [7:0] b_fc, s_fc;

  vga_timing_gen u_big (
    .clk(clk), .rst_n(b_rst_n), .ena(b_ena),
    .x(b_x), .y(b_y), .active(b_act), .hsync(b_hs), .vsync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  // 16 clocks per line (sync at x=10..12), 10 lines per frame (sync at y=7..8)
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE(1'b0)
  ) u_small (
    .clk(clk), .rst_n(s_rst_n), .ena(s_ena),
    .x(s_x), .y(s_y), .active(s_act), .hsync(s_hs), .vsync(s_vs),
    .line_start(s_ls), .frame_start(s_fs), .frame_count(s_fc)
  );

  int total = 0;
  int bad   = 0;
  int b_edges;

  typedef struct {
    int cyc;
    int x;
    int y;
    bit act;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
    int fc;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_big(input string tag, input vec_t v);
    chk({tag, ".x"}, 32'(b_x), 32'(v.x));
    chk({tag, ".y"}, 32'(b_y), 32'(v.y));
    chk({tag, ".active"}, 32'(b_act), 32'(v.act));
    chk({tag, ".hsync"}, 32'(b_hs), 32'(v.hs));
    chk({tag, ".vsync"}, 32'(b_vs), 32'(v.vs));
    chk({tag, ".line_start"}, 32'(b_ls), 32'(v.ls));
    chk({tag, ".frame_start"}, 32'(b_fs), 32'(v.fs));
    chk({tag, ".frame_count"}, 32'(b_fc), 32'(v.fc));
  endtask

  task automatic b_adv_to(input int c);
    while (b_edges < c) begin
      @(posedge clk);
      b_edges++;
    end
    @(negedge clk);
  endtask

  task automatic b_restart();
    @(negedge clk);
    b_rst_n = 1'b0;
    b_ena   = 1'b1;
    @(negedge clk);
    chk_big("big_reset", '{0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    b_rst_n = 1'b1;
    b_edges = 0;
  endtask

  initial begin
    int lo_cnt, lo_first, lo_last;
    b_rst_n = 1'b0; b_ena = 1'b0;
    s_rst_n = 1'b0; s_ena = 1'b0;

    //          cyc   x    y  act hs  vs  ls  fs  fc
    tbl[0]  = '{1,    0,   0, 1, 1, 1, 1, 1, 0};
    tbl[1]  = '{2,    1,   0, 1, 1, 1, 0, 0, 0};
    tbl[2]  = '{640,  639, 0, 1, 1, 1, 0, 0, 0};
    tbl[3]  = '{641,  640, 0, 0, 1, 1, 0, 0, 0};
    tbl[4]  = '{656,  655, 0, 0, 1, 1, 0, 0, 0};
    tbl[5]  = '{657,  656, 0, 0, 0, 1, 0, 0, 0};
    tbl[6]  = '{752,  751, 0, 0, 0, 1, 0, 0, 0};
    tbl[7]  = '{753,  752, 0, 0, 1, 1, 0, 0, 0};
    tbl[8]  = '{800,  799, 0, 0, 1, 1, 0, 0, 0};
    tbl[9]  = '{801,  0,   1, 1, 1, 1, 1, 0, 0};
    tbl[10] = '{802,  1,   1, 1, 1, 1, 0, 0, 0};
    tbl[11] = '{3101, 700, 3, 0, 0, 1, 0, 0, 0};

    b_restart();
    for (int i = 0; i < 11; i++) begin
      b_adv_to(tbl[i].cyc);
      chk_big($sformatf("vec%0d", i), tbl[i]);
    end

    // One whole line (y=1): measure the hsync-low window
    lo_cnt = 0; lo_first = -1; lo_last = -1;
    for (int i = 0; i < 798; i++) begin
      @(posedge clk);
      b_edges++;
      @(negedge clk);
      if (b_hs == 1'b0) begin
        lo_cnt++;
        if (lo_first < 0) lo_first = int'(b_x);
        lo_last = int'(b_x);
      end
    end
    chk("hsync_low_count", 32'(lo_cnt), 32'd96);
    chk("hsync_low_first_x", 32'(lo_first), 32'd656);
    chk("hsync_low_last_x", 32'(lo_last), 32'd751);
    chk("line_end_x", 32'(b_x), 32'd799);
    chk("line_end_y", 32'(b_y), 32'd1);

    // Asynchronous reset mid-frame, between clock edges, while hsync is asserted
    b_adv_to(tbl[11].cyc);
    chk_big("pre_async_reset", tbl[11]);
    @(posedge clk);
    #3 b_rst_n = 1'b0;
    #1 chk_big("async_reset", '{0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    @(negedge clk);
    b_rst_n = 1'b1;
    b_edges = 0;
    b_adv_to(1);
    chk_big("restart_vec0", tbl[0]);
    b_adv_to(2);
    chk_big("restart_vec1", tbl[1]);

    // ena held low at x=100,y=5 for 10 cycles
    b_restart();
    b_adv_to(4101);
    chk_big("pre_hold", '{0, 100, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    b_ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_big($sformatf("hold%0d", i), '{0, 100, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    end
    b_ena = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_big("resume", '{0, 101, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0});
    b_rst_n = 1'b0;
    b_ena   = 1'b0;

    // Shrunken instance: closed-form reference over 256 frames plus one frame_start
    @(negedge clk);
    s_ena = 1'b1;
    chk("small_reset_fc", 32'(s_fc), 32'd0);
    chk("small_reset_vsync", 32'(s_vs), 32'd1);
    s_rst_n = 1'b1;
    for (int k = 1; k <= 256 * 160 + 2; k++) begin
      int lin, ex, ey, efc;
      logic [14:0] got, exp;
      @(posedge clk);
      @(negedge clk);
      lin = k - 1;
      ex  = lin % 16;
      ey  = (lin / 16) % 10;
      efc = (lin / 160) % 256;
      exp = {4'(ex), 4'(ey), (ex < 8 && ey < 6), !(ex >= 10 && ex < 13),
             !(ey >= 7 && ey < 9), (ex == 0), (ex == 0 && ey == 0)};
      got = {s_x[3:0], s_y[3:0], s_act, s_hs, s_vs, s_ls, s_fs};
      total++;
      if (got !== exp || s_x[9:4] !== 6'd0 || s_y[9:4] !== 6'd0 || s_fc !== 8'(efc)) begin
        bad++;
        $display("FAIL small_cycle%0d: got x=%0d y=%0d flags=%b fc=%0d expected x=%0d y=%0d flags=%b fc=%0d",
                 k, s_x, s_y, got[6:0], s_fc, ex, ey, exp[6:0], efc);
      end
      if (k == 161) begin
        chk("frame2_start", 32'(s_fs), 32'd1);
        chk("frame2_count", 32'(s_fc), 32'd1);
      end
      if (k == 255 * 160 + 1) chk("frame256_count", 32'(s_fc), 32'd255);
      if (k == 256 * 160 + 1) begin
        chk("frame257_start", 32'(s_fs), 32'd1);
        chk("frame257_count_wrap", 32'(s_fc), 32'd0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
